// File: rtl/delay_line_memory_if.sv
// Processor-side command and read-response bundle for the delay-line memory.
// Both channels use valid/ready: a transfer happens on a posedge where valid and ready are both high.
interface delay_line_memory_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [WIDTH-1:0]  cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_rdata;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/delay_line_memory.sv
// Recirculating serial memory: a WIDTH*DEPTH-bit line shifted one bit per clock,
// with a word controller that writes or captures a word as it passes the tap.
module delay_line_memory #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2,
  localparam int DEPTH = 1 << ADDR_W,
  localparam int L     = WIDTH * DEPTH,
  localparam int POS_W = $clog2(L),
  localparam int J_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  delay_line_memory_if.slave bus,
  output logic             busy,
  output logic             dl_tap,
  output logic [POS_W-1:0] dl_pos,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [L-1:0]      line_q, line_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              started_q, started_d;

  logic [POS_W-1:0]  base;
  logic [POS_W-1:0]  last_pos;
  logic [POS_W-1:0]  offset;
  logic [J_W-1:0]    j;
  logic              in_win;
  logic              xfer;
  logic              in_bit;

  assign base     = POS_W'(addr_q) * POS_W'(WIDTH);
  assign last_pos = base + POS_W'(WIDTH - 1);
  assign offset   = pos_q - base;
  assign j        = offset[J_W-1:0];
  assign in_win   = (pos_q >= base) && (pos_q <= last_pos);

  // A transfer may only begin at bit 0 of the word; a command accepted while the
  // tap is already inside its window waits for the next lap.
  assign xfer = (state_q == S_ACTIVE) && ((pos_q == base) || (started_q && in_win));

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    started_d = started_q;
    in_bit    = line_q[0];
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          we_d      = bus.cmd_we;
          addr_d    = bus.cmd_addr;
          wdata_d   = bus.cmd_wdata;
          started_d = 1'b0;
          state_d   = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (xfer) begin
          started_d = 1'b1;
          if (we_q) begin
            in_bit = wdata_q[j];
          end else begin
            rdata_d[j] = line_q[0];
          end
          if (pos_q == last_pos) begin
            started_d = 1'b0;
            state_d   = we_q ? S_IDLE : S_RESP;
          end
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    line_d = {in_bit, line_q[L-1:1]};
    pos_d  = (pos_q == POS_W'(L - 1)) ? '0 : pos_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      line_q    <= '0;
      pos_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      pos_q     <= pos_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      started_q <= started_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign busy          = (state_q != S_IDLE);
  assign dl_tap        = line_q[0];
  assign dl_pos        = pos_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_delay_line_memory.sv
// Randomised bench for delay_line_memory: word-array model, latency from the
// window arithmetic, and a response scoreboard fed at command acceptance.
module tb_delay_line_memory;
  localparam int W     = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int L     = W * DEPTH;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic       dl_tap;
  logic [4:0] dl_pos;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  delay_line_memory_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

  delay_line_memory #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .dl_tap      (dl_tap),
    .dl_pos      (dl_pos),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mem[DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got 0x%0h with no read outstanding", bus.rsp_rdata);
      end else begin
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Leaves the bench just after the posedge that starts the cycle with dl_pos == p.
  task automatic wait_pos(input int p);
    int n;
    n = 0;
    @(negedge clk);
    while (int'(dl_pos) != (p + L - 1) % L && n < 2 * L) begin
      @(negedge clk);
      n++;
    end
    if (int'(dl_pos) != (p + L - 1) % L) check("wait_pos_timeout", 32'(dl_pos), 32'((p + L - 1) % L));
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input bit we, input int addr, input logic [W-1:0] data,
                         input int hold, input int target);
    int p0, lat, n;
    logic [W-1:0] expv;
    if (target >= 0) wait_pos(target);
    else begin
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = AW'(addr);
    bus.cmd_wdata = data;
    bus.rsp_ready = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 4 * L) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      check("accept_timeout", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    p0 = int'(dl_pos);
    @(posedge clk);
    #1;
    // Scramble the request fields: they must not matter after acceptance.
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'($urandom_range(0, 1));
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_wdata = W'($urandom);
    if (we) mem[addr] = data;
    else exp_q.push_back(mem[addr]);
    expv = mem[addr];
    lat = ((addr * W - (p0 + 1) + L) % L) + W;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == lat) check(we ? "wr_pre_done" : "rd_pre_done", {30'd0, busy, bus.rsp_valid}, 32'b10);
    end
    if (we) begin
      check("wr_done", {30'd0, bus.cmd_ready, busy}, 32'b10);
    end else begin
      check("rd_done", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'b10);
      if (hold > 0) begin
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'($urandom_range(0, 1));
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_wdata = W'($urandom);
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          check("hold_state", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'b10);
          check("hold_data", 32'(bus.rsp_rdata), 32'(expv));
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
      end
      @(negedge clk);
      check("rsp_release", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'b01);
    end
  endtask

  task automatic tap_lap();
    logic [L-1:0] got, expv;
    int p, prev, pos_err;
    got = '0;
    expv = '0;
    prev = 0;
    pos_err = 0;
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      p = int'(dl_pos);
      if (i > 0 && p != (prev + 1) % L) pos_err++;
      prev = p;
      got[p]  = dl_tap;
      expv[p] = mem[p / W][p % W];
    end
    check("tap_lap", 32'(got), 32'(expv));
    check("pos_sequence_errors", 32'(pos_err), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] wd;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {21'd0, bus.cmd_ready, busy, dl_pos, bus.rsp_valid, dl_tap, bus.rsp_rdata ^ 8'h00 ? 1'b1 : 1'b0},
          {21'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;

    run_cmd(1'b0, 2, 8'h00, 0, -1);
    run_cmd(1'b1, 1, 8'hA5, 0, 0);
    run_cmd(1'b0, 1, 8'h00, 2, -1);

    for (int a = 0; a < DEPTH; a++) run_cmd(1'b1, a, W'(8'h11 * (a + 1)), 0, -1);
    repeat (64) @(negedge clk);
    tap_lap();
    for (int a = DEPTH - 1; a >= 0; a--) run_cmd(1'b0, a, 8'h00, 0, -1);

    run_cmd(1'b0, 0, 8'h00, 0, 0);
    run_cmd(1'b0, 2, 8'h00, 10, -1);

    for (int i = 0; i < 40; i++) begin
      wd = W'($urandom);
      run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), wd,
              int'($urandom_range(0, 3)),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, L - 1)) : -1);
    end
    tap_lap();

    // Reset in the middle of a write to the last word.
    wait_pos(20);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_addr  = AW'(3);
    bus.cmd_wdata = 8'hFF;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (dl_pos != 5'd27 && n < 2 * L) begin
        @(negedge clk);
        n++;
      end
      check("reset_window_pos", 32'(dl_pos), 32'd27);
    end
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {19'd0, bus.cmd_ready, busy, dl_pos, bus.rsp_valid, dl_tap, bus.rsp_rdata},
          {19'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00});
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_cmd(1'b0, 3, 8'h00, 0, -1);
    tap_lap();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
